decoder_param_slot_tracker: RTL and testbench

DECODER_PARAM_SLOT_TRACKER -- requirements
Module: decoder_param_slot_tracker

---
 rtl/decoder_param_slot_tracker.sv | 115 +++++++++++
 tb/tb_decoder_param_slot_tracker.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/decoder_param_slot_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : decoder_param_slot_tracker
//  Description : Tracks allocation of SIZE slots. Accepts one set (allocate)
//                and one clear (release) request per cycle, reports a
//                registered one-hot decode of the accepted set, the occupancy
//                bitmap, the busy count, the lowest free slot and a one-cycle
//                error pulse for rejected requests.
//  Revision    : 1.0  initial release
// ============================================================================
module decoder_param_slot_tracker #(
    parameter int BITS = 2,
    parameter int SIZE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [BITS-1:0]   set_idx,
    input  logic              clr_en,
    input  logic [BITS-1:0]   clr_idx,
    output logic [SIZE-1:0]   dec_out,
    output logic [SIZE-1:0]   busy,
    output logic [BITS:0]     count,
    output logic [BITS-1:0]   free_idx,
    output logic              full,
    output logic              empty,
    output logic              err
);

    localparam logic [BITS:0] c_size = (BITS+1)'(SIZE);
    localparam logic [BITS:0] c_one  = (BITS+1)'(1);
    localparam logic [BITS:0] c_zero = '0;

    logic [SIZE-1:0] r_dec;
    logic [SIZE-1:0] r_busy;
    logic [BITS:0]   r_count;
    logic            r_err;

    logic [SIZE-1:0] w_set_oh;
    logic [SIZE-1:0] w_clr_oh;
    logic            w_set_legal;
    logic            w_clr_legal;
    logic            w_err;
    logic [SIZE-1:0] w_busy_nxt;
    logic [BITS:0]   w_count_nxt;
    logic [SIZE-1:0] w_dec_nxt;
    logic [BITS-1:0] w_free;

    // Decode both request indices; an index >= SIZE decodes to all-zero,
    // which makes it out-of-range without ever indexing past the bitmap.
    always_comb begin
        w_set_oh = '0;
        w_clr_oh = '0;
        for (int i = 0; i < SIZE; i++) begin
            w_set_oh[i] = ({1'b0, set_idx} == (BITS+1)'(i));
            w_clr_oh[i] = ({1'b0, clr_idx} == (BITS+1)'(i));
        end
    end

    // Legality, next-state and error evaluation. Clear is resolved first so a
    // set may reuse a slot released in the same cycle.
    always_comb begin
        w_clr_legal = clr_en && (|(w_clr_oh & r_busy));
        w_set_legal = set_en &&
                      (|(w_set_oh & (~r_busy | (w_clr_legal ? w_clr_oh : '0))));
        w_err       = (set_en && !w_set_legal) || (clr_en && !w_clr_legal);

        w_busy_nxt  = (r_busy & ~(w_clr_legal ? w_clr_oh : '0)) |
                      (w_set_legal ? w_set_oh : '0);
        w_dec_nxt   = w_set_legal ? w_set_oh : '0;

        w_count_nxt = r_count;
        if (w_set_legal && !w_clr_legal) begin
            w_count_nxt = r_count + c_one;
        end else if (w_clr_legal && !w_set_legal) begin
            w_count_nxt = r_count - c_one;
        end
    end

    // State registers; reset discards any concurrent request silently.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_busy  <= '0;
            r_count <= '0;
            r_dec   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_busy  <= w_busy_nxt;
            r_count <= w_count_nxt;
            r_dec   <= w_dec_nxt;
            r_err   <= w_err;
        end
    end

    // Lowest free slot: scan downwards so the lowest free index wins; a full
    // bitmap leaves the default of zero.
    always_comb begin
        w_free = '0;
        for (int i = SIZE - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_free = BITS'(i);
            end
        end
    end

    assign dec_out  = r_dec;
    assign busy     = r_busy;
    assign count    = r_count;
    assign free_idx = w_free;
    assign full     = (r_count == c_size);
    assign empty    = (r_count == c_zero);
    assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_decoder_param_slot_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decoder_param_slot_tracker
//  Description : Self-checking bench for decoder_param_slot_tracker with
//                BITS=3, SIZE=6. A reference model pushes expected outputs to
//                a queue as each request is driven; they are popped and
//                compared after the clock edge that registers the request.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_decoder_param_slot_tracker;

    localparam int BITS = 3;
    localparam int SIZE = 6;

    logic            clk;
    logic            rst;
    logic            set_en;
    logic [BITS-1:0] set_idx;
    logic            clr_en;
    logic [BITS-1:0] clr_idx;
    logic [SIZE-1:0] dec_out;
    logic [SIZE-1:0] busy;
    logic [BITS:0]   count;
    logic [BITS-1:0] free_idx;
    logic            full;
    logic            empty;
    logic            err;

    typedef struct packed {
        logic [SIZE-1:0] dec;
        logic [SIZE-1:0] busy;
        logic [BITS:0]   count;
        logic [BITS-1:0] free;
        logic            full;
        logic            empty;
        logic            err;
    } exp_t;

    exp_t q_exp[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // reference model state
    int   m_busy = 0;

    decoder_param_slot_tracker #(
        .BITS (BITS),
        .SIZE (SIZE)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .set_en   (set_en),
        .set_idx  (set_idx),
        .clr_en   (clr_en),
        .clr_idx  (clr_idx),
        .dec_out  (dec_out),
        .busy     (busy),
        .count    (count),
        .free_idx (free_idx),
        .full     (full),
        .empty    (empty),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running required finished");
        $fatal(1, "timeout");
    end

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance the model for one request and return the outputs it predicts
    // for the cycle after the clock edge.
    function automatic exp_t model_step(input bit r, input bit se, input int si,
                                        input bit ce, input int ci);
        exp_t e;
        bit   clr_ok;
        bit   set_ok;
        int   dec;
        e   = '0;
        dec = 0;
        if (!r) begin
            m_busy = 0;
            e.err  = 1'b0;
        end else begin
            clr_ok = ce && (ci < SIZE) && (((m_busy >> ci) & 1) == 1);
            set_ok = se && (si < SIZE) &&
                     ((((m_busy >> si) & 1) == 0) || (clr_ok && ci == si));
            if (clr_ok) m_busy = m_busy & ~(1 << ci);
            if (set_ok) begin
                m_busy = m_busy | (1 << si);
                dec    = 1 << si;
            end
            e.err = (se && !set_ok) || (ce && !clr_ok);
        end
        e.dec   = SIZE'(dec);
        e.busy  = SIZE'(m_busy);
        e.count = (BITS+1)'($countones(e.busy));
        e.free  = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (((m_busy >> i) & 1) == 0) begin
                e.free = BITS'(i);
                break;
            end
        end
        e.full  = (e.count == SIZE);
        e.empty = (e.count == 0);
        return e;
    endfunction

    // Drive one cycle of stimulus, queue the expectation, then compare.
    task automatic step(input bit r, input bit se, input int si,
                        input bit ce, input int ci, input string tag);
        exp_t e;
        @(negedge clk);
        rst     = r;
        set_en  = se;
        set_idx = BITS'(si);
        clr_en  = ce;
        clr_idx = BITS'(ci);
        q_exp.push_back(model_step(r, se, si, ce, ci));
        @(posedge clk);
        #1;
        e = q_exp.pop_front();
        check_val({tag, ".dec_out"},  32'(dec_out),  32'(e.dec));
        check_val({tag, ".busy"},     32'(busy),     32'(e.busy));
        check_val({tag, ".count"},    32'(count),    32'(e.count));
        check_val({tag, ".free_idx"}, 32'(free_idx), 32'(e.free));
        check_val({tag, ".full"},     32'(full),     32'(e.full));
        check_val({tag, ".empty"},    32'(empty),    32'(e.empty));
        check_val({tag, ".err"},      32'(err),      32'(e.err));
    endtask

    initial begin
        rst = 1'b0; set_en = 1'b0; set_idx = '0; clr_en = 1'b0; clr_idx = '0;

        // reset with concurrent requests: discarded, no err
        step(0, 1, 3, 1, 3, "rst0");
        step(0, 1, 3, 0, 0, "rst1");
        // first request accepted right after reset
        step(1, 1, 2, 0, 0, "set2");
        check_val("set2.dec_lit", 32'(dec_out), 32'h04);
        step(1, 0, 0, 0, 0, "idle");
        // fill the rest
        step(1, 1, 0, 0, 0, "set0");
        step(1, 1, 1, 0, 0, "set1");
        step(1, 1, 3, 0, 0, "set3");
        step(1, 1, 4, 0, 0, "set4");
        step(1, 1, 5, 0, 0, "set5");
        check_val("full.lit",  32'(full),  32'h1);
        check_val("count.lit", 32'(count), 32'h6);
        step(1, 1, 3, 0, 0, "set_full");
        step(1, 1, 7, 0, 0, "set_oor");
        // same-index set and clear while full
        step(1, 1, 4, 1, 4, "swap4");
        check_val("swap4.dec_lit", 32'(dec_out), 32'h10);
        // release down to slot 0 only
        for (int i = 1; i < SIZE; i++) step(1, 0, 0, 1, i, "clr");
        check_val("busy1.lit", 32'(busy), 32'h01);
        step(1, 0, 0, 1, 3, "clr_free");
        step(1, 0, 0, 1, 0, "clr0");
        check_val("empty.lit", 32'(empty), 32'h1);
        step(1, 0, 0, 1, 7, "clr_oor");
        // busy = 001011, illegal set 1 with legal clear 3
        step(1, 1, 0, 0, 0, "b_set0");
        step(1, 1, 1, 0, 0, "b_set1");
        step(1, 1, 3, 0, 0, "b_set3");
        step(1, 1, 1, 1, 3, "mixed");
        check_val("mixed.busy_lit", 32'(busy), 32'h03);
        // build 010110 then reset mid-operation
        step(1, 0, 0, 1, 0, "c_clr0");
        step(1, 1, 2, 0, 0, "c_set2");
        step(1, 1, 4, 0, 0, "c_set4");
        step(1, 1, 5, 0, 0, "rst_mid_pre");
        step(1, 0, 0, 1, 5, "c_clr5");
        check_val("pre_rst.lit", 32'(busy), 32'h16);
        step(0, 1, 0, 0, 0, "rst_mid");
        step(1, 0, 0, 0, 0, "post_rst");
        // random traffic with occasional reset
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 39) != 0),
                 ($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
                 ($urandom_range(0, 2) == 0), int'($urandom_range(0, 7)),
                 "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
